// File: rtl/fp64_minmax_reduce.sv
// Streaming FP64 min/max reducer with element indices and NaN status flags.
// Optional NaN propagation (first NaN wins, quieted) under FPMINMAX_NANPROP_EN.
module fp64_minmax_reduce #(
  parameter int unsigned CNTW = 16,
  parameter logic [63:0] QNAN = 64'h7FF8000000000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CNTW-1:0] len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     min_o,
  output logic [63:0]     max_o,
  output logic [CNTW-1:0] min_idx,
  output logic [CNTW-1:0] max_idx,
  output logic            nan_seen,
  output logic            snan_seen,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] len_q, cnt_q;
  logic            have_q;
  logic            xfer, is_nan, is_snan, upd_en;

  // Sign-magnitude strict less-than; -0 and +0 compare equal.
  function automatic logic fp_lt(input logic [63:0] a, input logic [63:0] b);
    logic r;
    if ((a[62:0] == 63'd0) && (b[62:0] == 63'd0)) r = 1'b0;
    else if (a[63] != b[63])                      r = a[63];
    else if (!a[63])                              r = (a[62:0] < b[62:0]);
    else                                          r = (a[62:0] > b[62:0]);
    return r;
  endfunction

  assign xfer    = in_valid & in_ready;
  assign is_nan  = (in_data[62:52] == 11'h7FF) && (in_data[51:0] != 52'd0);
  assign is_snan = is_nan && !in_data[51];

`ifdef FPMINMAX_NANPROP_EN
  logic lock_q;
  assign upd_en = !lock_q;
`else
  assign upd_en = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (xfer && (cnt_q == len_q - CNTW'(1))) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags track the next state so they are valid straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_d == ACCUM);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  // Accumulators start at the "no ordered element" result so len==0 needs no extra path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      cnt_q     <= '0;
      have_q    <= 1'b0;
      min_o     <= '0;
      max_o     <= '0;
      min_idx   <= '0;
      max_idx   <= '0;
      nan_seen  <= 1'b0;
      snan_seen <= 1'b0;
`ifdef FPMINMAX_NANPROP_EN
      lock_q    <= 1'b0;
`endif
    end else if ((state_q == IDLE) && start) begin
      len_q     <= len;
      cnt_q     <= '0;
      have_q    <= 1'b0;
      min_o     <= QNAN;
      max_o     <= QNAN;
      min_idx   <= '1;
      max_idx   <= '1;
      nan_seen  <= 1'b0;
      snan_seen <= 1'b0;
`ifdef FPMINMAX_NANPROP_EN
      lock_q    <= 1'b0;
`endif
    end else if (xfer) begin
      cnt_q <= cnt_q + CNTW'(1);
      if (is_nan) begin
        nan_seen <= 1'b1;
        if (is_snan) snan_seen <= 1'b1;
`ifdef FPMINMAX_NANPROP_EN
        if (!lock_q) begin
          lock_q  <= 1'b1;
          min_o   <= {in_data[63:52], 1'b1, in_data[50:0]};
          max_o   <= {in_data[63:52], 1'b1, in_data[50:0]};
          min_idx <= cnt_q;
          max_idx <= cnt_q;
        end
`endif
      end else if (upd_en) begin
        if (!have_q) begin
          have_q  <= 1'b1;
          min_o   <= in_data;
          max_o   <= in_data;
          min_idx <= cnt_q;
          max_idx <= cnt_q;
        end else begin
          if (fp_lt(in_data, min_o)) begin
            min_o   <= in_data;
            min_idx <= cnt_q;
          end
          if (fp_lt(max_o, in_data)) begin
            max_o   <= in_data;
            max_idx <= cnt_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fp64_minmax_reduce.sv
// Self-checking bench for fp64_minmax_reduce: vector table plus reset/hold sequences.
module tb_fp64_minmax_reduce;
  localparam int unsigned CNTW = 16;
  localparam int          NV   = 9;

  logic            clk = 1'b0;
  logic            rst, start, in_valid, out_ready;
  logic [CNTW-1:0] len;
  logic [63:0]     in_data;
  logic            in_ready, out_valid, nan_seen, snan_seen, busy;
  logic [63:0]     min_o, max_o;
  logic [CNTW-1:0] min_idx, max_idx;

  fp64_minmax_reduce #(.CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .min_o(min_o), .max_o(max_o), .min_idx(min_idx), .max_idx(max_idx),
    .nan_seen(nan_seen), .snan_seen(snan_seen), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 n;
    logic [7:0][63:0]   d;
    bit                 gap;
    int                 hold;
    logic [63:0]        mn, mx;
    logic [CNTW-1:0]    mni, mxi;
    logic               nan, snan;
  } vec_t;

  vec_t tv [NV];
  vec_t sb [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Runs one reduction; entered and left #1 after a rising edge.
  task automatic run(input vec_t v);
    int   i, cyc;
    logic rdy;
    vec_t e;
    sb.push_back(v);
    start = 1'b1; len = CNTW'(v.n);
    @(posedge clk); #1;
    start = 1'b0;
    i = 0; cyc = 0;
    while (i < v.n && cyc < 200) begin
      in_valid = v.gap ? (cyc % 2 == 0) : 1'b1;
      in_data  = v.d[i];
      if (v.gap && cyc == 1) begin start = 1'b1; len = CNTW'(7); end
      chk("out_valid_early", 64'(out_valid), 64'd0);
      rdy = in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (in_valid && rdy) i++;
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= 200) chk("feed_timeout", 64'(cyc), 64'd0);
    chk("out_valid_latency", 64'(out_valid), 64'd1);
    chk("in_ready_done", 64'(in_ready), 64'd0);
    if (out_valid && sb.size() > 0) begin
      e = sb.pop_front();
      for (int h = 0; h <= e.hold; h++) begin
        if (h > 0) begin @(posedge clk); #1; end
        chk("out_valid_hold", 64'(out_valid), 64'd1);
        chk("min_o", min_o, e.mn);
        chk("max_o", max_o, e.mx);
        chk("min_idx", 64'(min_idx), 64'(e.mni));
        chk("max_idx", 64'(max_idx), 64'(e.mxi));
        chk("nan_seen", 64'(nan_seen), 64'(e.nan));
        chk("snan_seen", 64'(snan_seen), 64'(e.snan));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", 64'(out_valid), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_min_o"}, min_o, 64'd0);
    chk({tag, "_max_o"}, max_o, 64'd0);
    chk({tag, "_idx"}, 64'({min_idx, max_idx}), 64'd0);
    chk({tag, "_flags"}, 64'({in_ready, out_valid, nan_seen, snan_seen, busy}), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < NV; k++) begin
      tv[k].n = 0; tv[k].d = '0; tv[k].gap = 1'b0; tv[k].hold = 0;
      tv[k].nan = 1'b0; tv[k].snan = 1'b0;
    end
    // mixed signs
    tv[0].n = 4; tv[0].d[0] = 64'h4008000000000000; tv[0].d[1] = 64'hBFF8000000000000;
    tv[0].d[2] = 64'h401C000000000000; tv[0].d[3] = 64'h0;
    tv[0].mn = 64'hBFF8000000000000; tv[0].mni = 16'd1;
    tv[0].mx = 64'h401C000000000000; tv[0].mxi = 16'd2;
    // signed zeros tie
    tv[1].n = 3; tv[1].d[1] = 64'h8000000000000000;
    tv[1].mn = 64'h0; tv[1].mni = 16'd0; tv[1].mx = 64'h0; tv[1].mxi = 16'd0;
    // SNaN, -inf, min subnormal
    tv[2].n = 3; tv[2].d[0] = 64'h7FF0000000000001; tv[2].d[1] = 64'hFFF0000000000000;
    tv[2].d[2] = 64'h0000000000000001; tv[2].nan = 1'b1; tv[2].snan = 1'b1;
`ifdef FPMINMAX_NANPROP_EN
    tv[2].mn = 64'h7FF8000000000001; tv[2].mni = 16'd0;
    tv[2].mx = 64'h7FF8000000000001; tv[2].mxi = 16'd0;
`else
    tv[2].mn = 64'hFFF0000000000000; tv[2].mni = 16'd1;
    tv[2].mx = 64'h0000000000000001; tv[2].mxi = 16'd2;
`endif
    // empty run, held output
    tv[3].n = 0; tv[3].hold = 5;
    tv[3].mn = 64'h7FF8000000000000; tv[3].mx = 64'h7FF8000000000000;
    tv[3].mni = 16'hFFFF; tv[3].mxi = 16'hFFFF;
    // gapped valid, stray start
    tv[4].n = 5; tv[4].gap = 1'b1;
    tv[4].d[0] = 64'h3FF0000000000000; tv[4].d[1] = 64'h4000000000000000;
    tv[4].d[2] = 64'h8000000000000000; tv[4].d[3] = 64'hC000000000000000;
    tv[4].d[4] = 64'h4020000000000000;
    tv[4].mn = 64'hC000000000000000; tv[4].mni = 16'd3;
    tv[4].mx = 64'h4020000000000000; tv[4].mxi = 16'd4;
    // single element after reset
    tv[5].n = 1; tv[5].d[0] = 64'h3FF0000000000000;
    tv[5].mn = 64'h3FF0000000000000; tv[5].mx = 64'h3FF0000000000000;
    tv[5].mni = 16'd0; tv[5].mxi = 16'd0;
    // all NaN (quiet then signalling)
    tv[6].n = 2; tv[6].d[0] = 64'h7FF8000000000000; tv[6].d[1] = 64'hFFF4000000000000;
    tv[6].nan = 1'b1; tv[6].snan = 1'b1;
`ifdef FPMINMAX_NANPROP_EN
    tv[6].mn = 64'h7FF8000000000000; tv[6].mx = 64'h7FF8000000000000;
    tv[6].mni = 16'd0; tv[6].mxi = 16'd0;
`else
    tv[6].mn = 64'h7FF8000000000000; tv[6].mx = 64'h7FF8000000000000;
    tv[6].mni = 16'hFFFF; tv[6].mxi = 16'hFFFF;
`endif
    // all negative
    tv[7].n = 3; tv[7].d[0] = 64'hC000000000000000; tv[7].d[1] = 64'hC008000000000000;
    tv[7].d[2] = 64'hBFF0000000000000;
    tv[7].mn = 64'hC008000000000000; tv[7].mni = 16'd1;
    tv[7].mx = 64'hBFF0000000000000; tv[7].mxi = 16'd2;
    // equal maxima keep the first
    tv[8].n = 3; tv[8].d[0] = 64'h4014000000000000; tv[8].d[1] = 64'h4014000000000000;
    tv[8].d[2] = 64'h3FF0000000000000;
    tv[8].mn = 64'h3FF0000000000000; tv[8].mni = 16'd2;
    tv[8].mx = 64'h4014000000000000; tv[8].mxi = 16'd0;

    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    chk_zero("reset");
    #20 rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 5; k++) run(tv[k]);

    // Abort mid-run with asynchronous reset
    start = 1'b1; len = CNTW'(4);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 64'hBFF0000000000000;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_idle_busy", 64'(busy), 64'd0);

    for (int k = 5; k < NV; k++) run(tv[k]);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp64_minmax_reduce.md
Name: fp64_minmax_reduce

Overview:
Streaming reducer that accepts a run of IEEE-754 binary64 operands over a valid/ready input and returns the minimum and maximum values, their element indices, and NaN status.
- Applies the same ordering the FPU compare path defines: sign-magnitude order, -0 == +0, NaN unordered.
- Sits beside the FPU as a vector-reduction helper; results are returned on a held valid/ready output.

Parameters:
CNTW, 16, width of length and index fields
QNAN, 64'h7FF8000000000000, canonical quiet NaN returned when no ordered element exists

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  begin a reduction; sampled only in IDLE
len  input  CNTW  number of elements in the run; sampled with start
in_valid  input  1  in_data is valid
in_ready  output  1  block accepts in_data this cycle
in_data  input  64  FP64 operand
out_valid  output  1  results valid; held until out_ready
out_ready  input  1  consumer accepts results
min_o  output  64  minimum value
max_o  output  64  maximum value
min_idx  output  CNTW  index (0-based) of min_o element
max_idx  output  CNTW  index of max_o element
nan_seen  output  1  at least one NaN element seen
snan_seen  output  1  at least one signalling NaN (quiet bit 0) seen
busy  output  1  state != IDLE

Behaviour:
- Interface: one clock (clk), asynchronous active-high reset (rst).
- Reset: state=IDLE, all outputs 0, internal counter 0. Reset asserted mid-run aborts the run with no output.
- States:
  - IDLE: in_ready=0. start=1 latches len, clears the accumulators and count, and sets nan/snan flags to 0. If len==0, go to DONE; else go to ACCUM.
  - ACCUM: in_ready=1. A transfer occurs when in_valid&in_ready; exactly one element per cycle. Each transfer increments count. The transfer with count==len-1 moves the state to DONE next cycle. start is ignored.
  - DONE: out_valid=1, in_ready=0. Outputs are stable until out_valid&out_ready, then the state returns to IDLE next cycle. out_valid drops in that same next cycle.
- Latency: out_valid rises the cycle after the last element is accepted. For len==0, out_valid rises the cycle after start.
- Classification of each element:
  - NaN when exp==all-ones and mantissa!=0.
  - SNaN when NaN and mantissa[51]==0.
  - Zero when exp==0 and mantissa==0.
- Ordering:
  - Different signs: the negative operand is less, except that two zeros are equal.
  - Both positive: compare {exp,man} unsigned.
  - Both negative: reversed unsigned compare.
  - Infinities and subnormals need no special case.
- Update rule:
  - NaN elements set nan_seen (and snan_seen if SNaN) and do not update min/max.
  - The first ordered element loads both min and max and both indices.
  - Later elements replace min only if strictly less, and max only if strictly greater. Ties, including -0 vs +0, keep the earlier element and its bit pattern.
- No ordered element (len==0 or all NaN): min_o=max_o=QNAN, min_idx=max_idx=all-ones.
- Index width: count wraps modulo 2^CNTW. len is limited to 2^CNTW-1, so the index never wraps within a legal run.
- in_data is ignored when in_valid=0 or in_ready=0.

Optional Feature:
FPMINMAX_NANPROP_EN
- Defined: NaN propagation.
  - The first NaN element loads min_o and max_o with its quieted pattern (mantissa[51] forced to 1, payload kept), and both indices are set to its index.
  - Later elements are still consumed to complete the run and still update nan_seen/snan_seen, but they do not change min/max/idx.
  - The all-NaN case returns the first NaN quieted, not QNAN.
- Undefined: NaNs are skipped exactly as described in Behaviour.

Test Plan:
1. len=4, data {3.0=4008000000000000, -1.5=BFF8000000000000, 7.0=401C000000000000, 0.0} -> min_o=BFF8000000000000 idx1, max_o=401C000000000000 idx2, nan_seen=0; out_valid exactly 1 cycle after the 4th transfer.
2. len=3, data {+0, -0, +0} -> min_o=max_o=0000000000000000, both idx0 (tie keeps first).
3. len=3, data {7FF0000000000001 (SNaN), FFF0000000000000 (-inf), 0000000000000001 (min subnormal)}:
   - Macro off -> min=-inf idx1, max=subnormal idx2, nan_seen=1, snan_seen=1.
   - Macro on -> min=max=7FF8000000000001 idx0.
4. start with len=0 -> out_valid next cycle; min=max=7FF8000000000000, idx=FFFF. Hold out_ready=0 for 5 cycles -> outputs stable; out_ready=1 -> IDLE and busy=0 next cycle.
5. len=5 with in_valid toggling 1,0,1,0,... -> exactly 5 transfers counted, correct indices; start pulsed during ACCUM is ignored.
6. Assert rst after 2 of 4 elements -> all outputs 0 immediately (async), state IDLE. A new start with len=1, data 1.0 -> min=max=3FF0000000000000 idx0.
